// File: rtl/sentinel_pkg.sv
// Shared state encoding and 7-segment status codes for the sentinel attempt controller.
package sentinel_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CHECK   = 2'd1,
        GRANTED = 2'd2,
        LOCKOUT = 2'd3
    } state_t;

    // Segment patterns are {dp,g,f,e,d,c,b,a}, active low.
    localparam logic [7:0] SEG_LOCKED   = 8'hC7;
    localparam logic [7:0] SEG_UNLOCKED = 8'hC1;
    localparam logic [7:0] SEG_LOCKOUT  = 8'hBF;
    localparam logic [7:0] SEG_OFF      = 8'hFF;

    // Status glyph shown for a given controller state.
    function automatic logic [7:0] segFor(input state_t s);
        logic [7:0] seg;
        seg = SEG_LOCKED;
        case (s)
            GRANTED: seg = SEG_UNLOCKED;
            LOCKOUT: seg = SEG_LOCKOUT;
            default: seg = SEG_LOCKED;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/sentinel_sync_edge.sv
// Multi-flop synchroniser for the raw SUBMIT button plus a one-cycle rising-edge pulse.
module sentinel_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_rise
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    // Shift the button through the synchroniser and keep the previous settled sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_rise = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule

// File: rtl/sentinel_attempt_ctrl.sv
// Attempt sequencer and lockout controller: latches the key on a press, checks it for one
// cycle, then grants a timed unlock or counts the failure, locking out with exponential backoff.
module sentinel_attempt_ctrl
    import sentinel_pkg::*;
#(
    parameter int MAX_FAILS    = 3,
    parameter int LOCKOUT_BASE = 1024,
    parameter int MAX_BACKOFF  = 4,
    parameter int GRANT_CYCLES = 4096,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] key_in,
    input  logic       submit,
    output logic [7:0] cmp_key,
    output logic       cmp_valid,
    input  logic       cmp_match,
    output logic       unlocked,
    output logic       locked_out,
    output logic [2:0] fail_count,
    output logic [7:0] seg_out,
    output logic       glow_en
);

    localparam int LOCK_MAX = LOCKOUT_BASE << MAX_BACKOFF;
    localparam int SPAN_MAX = (GRANT_CYCLES > LOCK_MAX) ? GRANT_CYCLES : LOCK_MAX;
    localparam int TW       = $clog2(SPAN_MAX);
    localparam int BW       = (MAX_BACKOFF < 1) ? 1 : $clog2(MAX_BACKOFF + 1);

    state_t          r_state,   w_stateNext;
    logic [TW-1:0]   r_timer,   w_timerNext;
    logic [2:0]      r_fails,   w_failsNext;
    logic [BW-1:0]   r_backoff, w_backoffNext;
    logic [7:0]      r_cmpKey,  w_cmpKeyNext;
    logic [7:0]      r_seg,     w_segNext;
    logic            w_rise;
    logic [31:0]     w_lockSpan;

    sentinel_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_async(submit),
        .o_rise (w_rise)
    );

    // Lockout length doubles with each backoff step; the counter is loaded with one less.
    assign w_lockSpan = 32'(LOCKOUT_BASE) << r_backoff;

    // State, timer, failure/backoff counters, latched key and the registered status glyph.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_timer   <= '0;
            r_fails   <= '0;
            r_backoff <= '0;
            r_cmpKey  <= '0;
            r_seg     <= SEG_OFF;
        end else begin
            r_state   <= w_stateNext;
            r_timer   <= w_timerNext;
            r_fails   <= w_failsNext;
            r_backoff <= w_backoffNext;
            r_cmpKey  <= w_cmpKeyNext;
            r_seg     <= w_segNext;
        end
    end

    // Next-state logic; with ena low everything holds and presses are dropped.
    always_comb begin
        w_stateNext   = r_state;
        w_timerNext   = r_timer;
        w_failsNext   = r_fails;
        w_backoffNext = r_backoff;
        w_cmpKeyNext  = r_cmpKey;
        if (ena) begin
            case (r_state)
                IDLE: begin
                    if (w_rise) begin
                        w_cmpKeyNext = key_in;
                        w_stateNext  = CHECK;
                    end
                end
                CHECK: begin
                    if (cmp_match) begin
                        w_stateNext   = GRANTED;
                        w_timerNext   = TW'(GRANT_CYCLES - 1);
                        w_failsNext   = '0;
                        w_backoffNext = '0;
                    end else if (({1'b0, r_fails} + 4'd1) < 4'(MAX_FAILS)) begin
                        w_failsNext = r_fails + 3'd1;
                        w_stateNext = IDLE;
                    end else begin
                        w_stateNext   = LOCKOUT;
                        w_timerNext   = TW'(w_lockSpan - 32'd1);
                        w_failsNext   = 3'(MAX_FAILS);
                        w_backoffNext = (r_backoff == BW'(MAX_BACKOFF)) ? r_backoff
                                                                         : r_backoff + BW'(1);
                    end
                end
                GRANTED: begin
                    if (w_rise || r_timer == '0) begin
                        w_stateNext = IDLE;
                        w_timerNext = '0;
                    end else begin
                        w_timerNext = r_timer - TW'(1);
                    end
                end
                LOCKOUT: begin
                    if (r_timer == '0) begin
                        w_stateNext = IDLE;
                        w_failsNext = '0;
                    end else begin
                        w_timerNext = r_timer - TW'(1);
                    end
                end
                default: w_stateNext = IDLE;
            endcase
        end
        w_segNext = ena ? segFor(w_stateNext) : SEG_OFF;
    end

    assign cmp_key    = r_cmpKey;
    assign cmp_valid  = (r_state == CHECK) & ena;
    assign unlocked   = (r_state == GRANTED) & ena;
    assign glow_en    = unlocked;
    assign locked_out = (r_state == LOCKOUT);
    assign fail_count = r_fails;
    assign seg_out    = r_seg;

endmodule

// File: doc/sentinel_attempt_ctrl.md
Name: sentinel_attempt_ctrl

Overview:
Attempt sequencer and lockout controller for the perimeter key comparator.
- Synchronises the operator SUBMIT button and latches the DIP-switch key on its rising edge.
- Presents the latched key to the comparator datapath for one check cycle, then grants or refuses.
- Counts consecutive failures and enforces a timed lockout with exponential backoff.
- Drives the 7-segment status code and the status-array glow enable. Sits between the UI pins and the comparator.

Parameters:
MAX_FAILS, 3, consecutive failed attempts that trigger lockout (range 1..7)
LOCKOUT_BASE, 1024, first lockout duration in clk cycles (power of two, ≥2)
MAX_BACKOFF, 4, maximum doubling exponent applied to LOCKOUT_BASE
GRANT_CYCLES, 4096, cycles the gate stays unlocked before auto-relock (≥2)
SYNC_STAGES, 2, flops in the submit synchroniser (≥2)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
ena  in  1  power-state enable
key_in  in  8  DIP-switch key, assumed static while submitting
submit  in  1  raw asynchronous SUBMIT button, active high
cmp_key  out  8  latched key presented to comparator
cmp_valid  out  1  high only in CHECK
cmp_match  in  1  combinational comparator result for cmp_key
unlocked  out  1  gate open
locked_out  out  1  lockout active
fail_count  out  3  consecutive failures since last success/lockout exit
seg_out  out  8  7-seg {dp,g,f,e,d,c,b,a}, active low
glow_en  out  1  status-array drive (= unlocked & ena)

Behaviour:
- Reset (async assert, sync release): state IDLE, cmp_key=0x00, cmp_valid=0, unlocked=0, locked_out=0, fail_count=0, backoff=0, timers=0, sync flops=0, seg_out=0xFF.
- submit_rise: synchroniser last stage high and previous sample low; exactly one pulse per press, no debounce beyond sync.
- States:
  - IDLE: on submit_rise latch key_in→cmp_key, go CHECK.
  - CHECK (one cycle, cmp_valid=1):
    - cmp_match=1 → GRANTED; load grant timer=GRANT_CYCLES-1; clear fail_count and backoff.
    - cmp_match=0 with fail_count+1 < MAX_FAILS → fail_count++, IDLE.
    - cmp_match=0 with fail_count+1 == MAX_FAILS → LOCKOUT; load timer=(LOCKOUT_BASE<<backoff)-1; backoff=min(backoff+1, MAX_BACKOFF); fail_count=MAX_FAILS.
  - GRANTED: unlocked=1; timer decrements; at 0 → IDLE. submit_rise → IDLE immediately (manual relock).
  - LOCKOUT: locked_out=1; submit_rise ignored; timer decrements; at 0 → IDLE, fail_count=0, backoff retained.
- Latency: submit high sampled at edge E0 → rise seen after E(SYNC_STAGES-1) → CHECK after next edge → unlocked after the following edge. Default: 4 edges.
- GRANTED lasts exactly GRANT_CYCLES cycles. LOCKOUT lasts exactly LOCKOUT_BASE<<b cycles, where b is the backoff value before the increment.
- Timer width: $clog2(max(GRANT_CYCLES, LOCKOUT_BASE<<MAX_BACKOFF)). No wrap: decrement stops at 0.
- seg_out (registered):
  - IDLE/CHECK: 0xC7 ('L').
  - GRANTED: 0xC1 ('U').
  - LOCKOUT: 0xBF ('-').
  - ena=0: 0xFF.
- ena=0:
  - FSM and timers freeze; no submit accepted; sync flops keep sampling.
  - unlocked, glow_en and cmp_valid gate to 0; locked_out still reflects state.
  - Lockout cannot be escaped by toggling ena.
- Reset mid-LOCKOUT or mid-GRANTED: full clear, as above.
- Press held through CHECK: single attempt only.

Decomposition:
- Package sentinel_pkg: state enum (IDLE, CHECK, GRANTED, LOCKOUT); SEG_LOCKED=0xC7, SEG_UNLOCKED=0xC1, SEG_LOCKOUT=0xBF, SEG_OFF=0xFF.
- Sub-module sentinel_sync_edge: SYNC_STAGES synchroniser plus rising-edge pulse, async active-low reset.

Test Plan:
- Key 0xB6, comparator matches, one press → CHECK 3 edges after press sampled; unlocked=1, seg_out=0xC1, glow_en=1 for exactly 4096 cycles, then seg_out=0xC7.
- Wrong key 0x00 pressed 3 times → fail_count 1,2 then locked_out=1, seg_out=0xBF for 1024 cycles; presses during lockout ignored; exit → fail_count=0.
- Second lockout (3 more failures) → 2048 cycles; after five lockouts the duration saturates at 16384; one success then resets backoff → next lockout 1024.
- GRANTED, press at cycle 100 → IDLE next cycle, unlocked=0.
- rst_n low mid-LOCKOUT (cycle 500) → all outputs at reset values asynchronously; next wrong press gives fail_count=1.
- ena=0 during LOCKOUT for 300 cycles → seg_out=0xFF, timer frozen; total lockout = 1024 enabled cycles; ena=0 in GRANTED → unlocked=0, glow_en=0.
